// File: rtl/snake_game_control.sv
`timescale 1ns/1ps
// snake_game_control: snake motion/collision engine for the world renderer.
//   Holds the head and body positions in pixel coordinates and steps one pixel
//   per move tick. Detects food, wall and self hits, and flags body pixels at
//   the current raster position.
//   Optional feature: define SNAKE_WRAP_EN to make the head wrap at the
//   playfield edges instead of dying.
// Ports:
//   Clock          system clock, all state on the rising edge
//   Reset          asynchronous active-low reset
//   iStart         level; starts or restarts a game from IDLE or OVER
//   iDirection     {up,down,left,right} one-hot button request
//   iFoodLocationX food column;  iFoodLocationY food row
//   iPixelRow      raster row;   iPixelCol      raster column
//   oSnakeLenght   current length in segments
//   oGameOver      high in OVER
//   oRandEn        one-cycle food-eaten strobe
//   oSnakePixel    raster position lies on a live segment (combinational)
//   oHeadX/oHeadY  current head column/row
module snake_game_control #(
   parameter int MAX_LEN  = 96,
   parameter int INIT_LEN = 3,
   parameter int WIN_LEN  = 95,
   parameter int TICK_DIV = 1000000,
   parameter int LIM_L    = 192,
   parameter int LIM_R    = 448,
   parameter int LIM_U    = 112,
   parameter int LIM_D    = 368
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        iStart,
   input  logic [3:0]  iDirection,
   input  logic [10:0] iFoodLocationX,
   input  logic [10:0] iFoodLocationY,
   input  logic [10:0] iPixelRow,
   input  logic [10:0] iPixelCol,
   output logic [7:0]  oSnakeLenght,
   output logic        oGameOver,
   output logic        oRandEn,
   output logic        oSnakePixel,
   output logic [10:0] oHeadX,
   output logic [10:0] oHeadY
);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [7:0] INIT_L8 = 8'(INIT_LEN);
   localparam logic [7:0] WIN_L8 = 8'(WIN_LEN);
   localparam logic [7:0] MAX_L8 = 8'(MAX_LEN);
   localparam logic [10:0] X_L = 11'(LIM_L);
   localparam logic [10:0] X_R = 11'(LIM_R);
   localparam logic [10:0] Y_U = 11'(LIM_U);
   localparam logic [10:0] Y_D = 11'(LIM_D);
   localparam int HOME_X = 320;
   localparam logic [10:0] HOME_Y = 11'd240;
   localparam logic [3:0] UP = 4'b1000;
   localparam logic [3:0] DOWN = 4'b0100;
   localparam logic [3:0] LEFT = 4'b0010;
   localparam logic [3:0] RIGHT = 4'b0001;

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

   state_t state, state_nx;
   logic [10:0] seg_x [MAX_LEN];
   logic [10:0] seg_y [MAX_LEN];
   logic [7:0] len;
   logic [3:0] dir;
   logic [TW-1:0] cnt;
   logic rand_en;

   logic start, run, step, win, eat, wall, self_hit, hit, dir_ok, pix;
   logic [10:0] raw_x, raw_y, nx, ny;
   logic [3:0] rev;

   assign run = state == RUN;
   assign start = !run && iStart;
   assign step = run && cnt == TICK_LAST;
   assign win = len >= WIN_L8;
   // dir holds the most recently accepted request, so reversal is judged
   // against it; this lets two quick turns make a U-turn within one tick.
   assign rev = {dir[2], dir[3], dir[0], dir[1]};
   assign dir_ok = (iDirection == UP || iDirection == DOWN || iDirection == LEFT ||
                    iDirection == RIGHT) && iDirection != rev;

   always_comb begin
      raw_x = dir == RIGHT ? seg_x[0] + 11'd1 : dir == LEFT ? seg_x[0] - 11'd1 : seg_x[0];
      raw_y = dir == DOWN ? seg_y[0] + 11'd1 : dir == UP ? seg_y[0] - 11'd1 : seg_y[0];
`ifdef SNAKE_WRAP_EN
      nx = raw_x < X_L ? X_R : raw_x > X_R ? X_L : raw_x;
      ny = raw_y < Y_U ? Y_D : raw_y > Y_D ? Y_U : raw_y;
      wall = 1'b0;
`else
      nx = raw_x;
      ny = raw_y;
      wall = raw_x < X_L || raw_x > X_R || raw_y < Y_U || raw_y > Y_D;
`endif
   end

   assign eat = nx == iFoodLocationX && ny == iFoodLocationY;

   // The tail cell is vacated by a plain move, so it only collides when the
   // snake grows on this step and the tail stays put.
   always_comb begin
      self_hit = 1'b0;
      for (int k = 1; k < MAX_LEN; k++)
         if (seg_x[k] == nx && seg_y[k] == ny &&
             (8'(k) + 8'd1 < len || (eat && 8'(k) + 8'd1 == len)))
            self_hit = 1'b1;
   end

   assign hit = wall || self_hit;

   always_comb begin
      pix = 1'b0;
      for (int k = 0; k < MAX_LEN; k++)
         if (8'(k) < len && seg_x[k] == iPixelCol && seg_y[k] == iPixelRow)
            pix = 1'b1;
   end

   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      state_nx = start ? RUN : (run && (win || (step && hit))) ? OVER : state;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         len <= INIT_L8;
         dir <= RIGHT;
         cnt <= '0;
         rand_en <= 1'b0;
         for (int k = 0; k < MAX_LEN; k++) begin
            seg_x[k] <= 11'(HOME_X - k);
            seg_y[k] <= HOME_Y;
         end
      end else begin
         rand_en <= step && !hit && eat;
         if (start) begin
            len <= INIT_L8;
            dir <= RIGHT;
            cnt <= '0;
            for (int k = 0; k < MAX_LEN; k++) begin
               seg_x[k] <= 11'(HOME_X - k);
               seg_y[k] <= HOME_Y;
            end
         end else if (run) begin
            cnt <= step ? '0 : cnt + 1'b1;
            if (dir_ok) dir <= iDirection;
            // The whole array shifts every move; growing just exposes the
            // old tail, which the shift has already copied one slot deeper.
            if (step && !hit) begin
               for (int k = MAX_LEN - 1; k > 0; k--) begin
                  seg_x[k] <= seg_x[k-1];
                  seg_y[k] <= seg_y[k-1];
               end
               seg_x[0] <= nx;
               seg_y[0] <= ny;
               if (eat && len != MAX_L8) len <= len + 8'd1;
            end
         end
      end
   end

   assign oSnakeLenght = len;
   assign oGameOver = state == OVER;
   assign oRandEn = rand_en;
   assign oSnakePixel = pix;
   assign oHeadX = seg_x[0];
   assign oHeadY = seg_y[0];
endmodule

// File: tb/tb_snake_game_control.sv
`timescale 1ns/1ps
// tb_snake_game_control: directed bench with a queue-based reference model.
module tb_snake_game_control;
   localparam int TD = 4;
   localparam logic [3:0] UP = 4'b1000;
   localparam logic [3:0] DOWN = 4'b0100;
   localparam logic [3:0] LEFT = 4'b0010;
   localparam logic [3:0] RIGHT = 4'b0001;

   typedef logic [21:0] pos_t;

   logic Clock = 0, Reset = 0, iStart = 0;
   logic [3:0] iDirection = 0;
   logic [10:0] iFoodLocationX = 0, iFoodLocationY = 0, iPixelRow = 240, iPixelCol = 320;
   logic [7:0] oSnakeLenght;
   logic oGameOver, oRandEn, oSnakePixel;
   logic [10:0] oHeadX, oHeadY;

   snake_game_control #(.TICK_DIV(TD)) dut (
      .Clock(Clock), .Reset(Reset), .iStart(iStart), .iDirection(iDirection),
      .iFoodLocationX(iFoodLocationX), .iFoodLocationY(iFoodLocationY),
      .iPixelRow(iPixelRow), .iPixelCol(iPixelCol), .oSnakeLenght(oSnakeLenght),
      .oGameOver(oGameOver), .oRandEn(oRandEn), .oSnakePixel(oSnakePixel),
      .oHeadX(oHeadX), .oHeadY(oHeadY));

   always #5 Clock = ~Clock;

   int tests = 0, fails = 0;
   bit armed = 0, feed = 0;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // reference model: body as a queue, head at the front
   pos_t mq[$];
   int m_state = 0;
   int m_cnt = 0;
   int m_steps = 0;
   logic [3:0] m_dir = RIGHT;
   bit m_rand = 0;

   function automatic pos_t mk(int x, int y);
      return {11'(x), 11'(y)};
   endfunction

   function automatic bit opposite(logic [3:0] a, logic [3:0] b);
      return (a == UP && b == DOWN) || (a == DOWN && b == UP) ||
             (a == LEFT && b == RIGHT) || (a == RIGHT && b == LEFT);
   endfunction

   function automatic bit in_body(logic [10:0] col, logic [10:0] row);
      foreach (mq[i]) if (mq[i] == {col, row}) return 1;
      return 0;
   endfunction

   task automatic m_reload();
      mq.delete();
      for (int i = 0; i < 3; i++) mq.push_back(mk(320 - i, 240));
      m_dir = RIGHT;
      m_cnt = 0;
   endtask

   task automatic m_step(output bit r);
      int x, y;
      bit eat, hit;
      r = 0;
      hit = 0;
      m_steps++;
      x = int'(mq[0][21:11]);
      y = int'(mq[0][10:0]);
      if (m_dir == UP) y--;
      else if (m_dir == DOWN) y++;
      else if (m_dir == LEFT) x--;
      else x++;
`ifdef SNAKE_WRAP_EN
      if (x < 192) x = 448; else if (x > 448) x = 192;
      if (y < 112) y = 368; else if (y > 368) y = 112;
`else
      if (x < 192 || x > 448 || y < 112 || y > 368) hit = 1;
`endif
      eat = x == int'(iFoodLocationX) && y == int'(iFoodLocationY);
      for (int i = 1; i < mq.size(); i++)
         if (mq[i] == mk(x, y) && (i < mq.size() - 1 || eat)) hit = 1;
      if (hit) m_state = 2;
      else begin
         mq.push_front(mk(x, y));
         if (eat) r = 1; else void'(mq.pop_back());
      end
   endtask

   always @(posedge Clock or negedge Reset) begin
      bit r;
      r = 0;
      if (!Reset) begin
         m_reload();
         m_state = 0;
      end else if (m_state != 1 && iStart) begin
         m_reload();
         m_state = 1;
      end else if (m_state == 1) begin
         if (mq.size() >= 95) m_state = 2;
         else begin
            if (m_cnt == TD - 1) begin
               m_cnt = 0;
               m_step(r);
            end else m_cnt++;
            if ($countones(iDirection) == 1 && !opposite(iDirection, m_dir)) m_dir = iDirection;
         end
      end
      m_rand = r;
   end

   always @(posedge Clock) begin
      #1;
      if (armed) begin
         chk("len", int'(oSnakeLenght), mq.size());
         chk("game_over", int'(oGameOver), int'(m_state == 2));
         chk("rand_en", int'(oRandEn), int'(m_rand));
         chk("head_x", int'(oHeadX), int'(mq[0][21:11]));
         chk("head_y", int'(oHeadY), int'(mq[0][10:0]));
         chk("pixel", int'(oSnakePixel), int'(in_body(iPixelCol, iPixelRow)));
      end
   end

   task automatic tick();
      pos_t p;
      int r;
      @(negedge Clock);
      r = $urandom_range(0, 3);
      p = r == 0 ? mq[0] : r == 1 ? mq[mq.size()-1] :
          r == 2 ? mq[$urandom_range(0, mq.size() - 1)] : mq[mq.size()-1] - 22'(1 << 11);
      iPixelCol = p[21:11];
      iPixelRow = p[10:0];
      if (feed) begin
         iFoodLocationX = mq[0][21:11] + 11'd1;
         iFoodLocationY = mq[0][10:0];
      end
   endtask

   task automatic wait_step();
      int s, n;
      s = m_steps;
      n = 0;
      while (m_steps == s && n < 20) begin
         tick();
         n++;
      end
      if (m_steps == s) begin
         tests++;
         fails++;
         $display("FAIL step_timeout: got no step after %0d cycles, expected one", n);
      end
   endtask

   task automatic turn(logic [3:0] d);
      iDirection = d;
      tick();
      iDirection = 0;
      wait_step();
   endtask

   task automatic restart();
      iStart = 1;
      tick();
      iStart = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      m_reload();
      iFoodLocationX = 323;
      iFoodLocationY = 240;
      #12;
      chk("rst_len", int'(oSnakeLenght), 3);
      chk("rst_over", int'(oGameOver), 0);
      chk("rst_rand", int'(oRandEn), 0);
      chk("rst_head_x", int'(oHeadX), 320);
      chk("rst_head_y", int'(oHeadY), 240);
      iPixelCol = 318;
      #1 chk("rst_pix_tail", int'(oSnakePixel), 1);
      iPixelCol = 317;
      #1 chk("rst_pix_beyond", int'(oSnakePixel), 0);
      tick();
      Reset = 1;
      armed = 1;
      tick();
      // first step and first food
      restart();
      repeat (4) tick();
      chk("step1_head_x", int'(oHeadX), 321);
      chk("step1_len", int'(oSnakeLenght), 3);
      chk("step1_over", int'(oGameOver), 0);
      repeat (8) tick();
      chk("eat_rand", int'(oRandEn), 1);
      chk("eat_len", int'(oSnakeLenght), 4);
      tick();
      chk("eat_rand_off", int'(oRandEn), 0);
      iFoodLocationX = 0;
      iFoodLocationY = 0;
      // reversal ignored, then a quick up+left U-turn
      wait_step();
      turn(LEFT);
      chk("rev_ignored_x", int'(oHeadX), 325);
      chk("rev_ignored_over", int'(oGameOver), 0);
      iDirection = UP;
      tick();
      iDirection = LEFT;
      tick();
      iDirection = 0;
      wait_step();
      chk("uturn_over", int'(oGameOver), 1);
      chk("uturn_head_x", int'(oHeadX), 325);
      // tail chasing in a 2x2 square, then eating onto the tail
      restart();
      chk("restart_len", int'(oSnakeLenght), 3);
      chk("restart_over", int'(oGameOver), 0);
      chk("restart_head_x", int'(oHeadX), 320);
      iFoodLocationX = 321;
      iFoodLocationY = 240;
      wait_step();
      iFoodLocationX = 0;
      iFoodLocationY = 0;
      turn(UP);
      turn(LEFT);
      turn(DOWN);
      chk("tail_chase_over", int'(oGameOver), 0);
      chk("tail_chase_y", int'(oHeadY), 240);
      turn(RIGHT);
      chk("tail_chase2_x", int'(oHeadX), 321);
      iFoodLocationX = 321;
      iFoodLocationY = 239;
      turn(UP);
      chk("tail_eat_over", int'(oGameOver), 1);
      chk("tail_eat_len", int'(oSnakeLenght), 4);
      tick();
      chk("tail_eat_rand", int'(oRandEn), 0);
      iFoodLocationX = 0;
      iFoodLocationY = 0;
      // right wall
      restart();
      repeat (128) wait_step();
      chk("wall_edge_x", int'(oHeadX), 448);
      chk("wall_edge_over", int'(oGameOver), 0);
      wait_step();
`ifdef SNAKE_WRAP_EN
      chk("wrap_x", int'(oHeadX), 192);
      chk("wrap_over", int'(oGameOver), 0);
      iDirection = UP;
      tick();
      iDirection = LEFT;
      tick();
      iDirection = 0;
      wait_step();
      chk("wrap_uturn_over", int'(oGameOver), 1);
`else
      chk("wall_over", int'(oGameOver), 1);
      chk("wall_head_x", int'(oHeadX), 448);
`endif
      // grow to the win length by eating every step
      restart();
      feed = 1;
      for (int n = 0; n < 1000 && mq.size() < 95; n++) tick();
      feed = 0;
      chk("win_len", int'(oSnakeLenght), 95);
      chk("win_over_early", int'(oGameOver), 0);
      tick();
      chk("win_over", int'(oGameOver), 1);
      chk("win_len_hold", int'(oSnakeLenght), 95);
      restart();
      chk("win_restart_len", int'(oSnakeLenght), 3);
      chk("win_restart_over", int'(oGameOver), 0);
      // asynchronous reset while the food strobe is high
      iFoodLocationX = 321;
      iFoodLocationY = 240;
      wait_step();
      chk("pre_rst_rand", int'(oRandEn), 1);
      #2 Reset = 0;
      #1;
      chk("arst_len", int'(oSnakeLenght), 3);
      chk("arst_over", int'(oGameOver), 0);
      chk("arst_rand", int'(oRandEn), 0);
      chk("arst_head_x", int'(oHeadX), 320);
      chk("arst_head_y", int'(oHeadY), 240);
      tick();
      tick();
      Reset = 1;
      repeat (6) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
